// File: rtl/nibble_link_pkg.sv
// Shared definitions for the 4-bit nibble link (transmit and receive sides):
// nibble width, default word length and the handshake state encoding.
package nibble_link_pkg;

  localparam int NIBBLE_W        = 4;
  localparam int NIBBLES_DEFAULT = 8;

  // 2'b11 is never entered; any block using this type decodes it as IDLE.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PRESENT = 2'b01,
    RELEASE = 2'b10
  } link_state_t;

  // Even parity bit for one nibble (ones in nibble plus parity bit is even).
  function automatic logic nibble_parity(input logic [NIBBLE_W-1:0] nib);
    return ^nib;
  endfunction

endpackage

// File: rtl/nibble_sync.sv
// Parameterised flop chain that brings an asynchronous level into the clk
// domain. STAGES must be at least 2.
module nibble_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  // Shift the raw input through the chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain_reg <= '0;
    end else begin
      chain_reg <= {chain_reg[STAGES-2:0], d};
    end
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/pcpi_result_nibble_tx.sv
// Transmit side of the nibble link: serialises a PCPI result word LSB nibble
// first over a 4-phase valid/ack handshake. tx_ack is asynchronous and passes
// through a nibble_sync chain before the FSM sees it.
// Optional build macro NIBBLE_TX_PARITY_EN adds a registered even-parity bit
// on tx_parity; without it tx_parity is tied low.
module pcpi_result_nibble_tx
  import nibble_link_pkg::*;
#(
  parameter int NIBBLES     = NIBBLES_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_valid,
  input  logic [NIBBLE_W*NIBBLES-1:0] load_data,
  output logic                      load_ready,
  output logic [NIBBLE_W-1:0]       tx_nibble,
  output logic                      tx_valid,
  input  logic                      tx_ack,
  output logic                      tx_parity,
  output logic                      busy,
  output logic                      done
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

  link_state_t          state_reg;
  logic [W-1:0]         shift_reg;
  logic [W-1:0]         shift_next;
  logic [CNT_W-1:0]     count_reg;
  logic [NIBBLE_W-1:0]  tx_nibble_reg;
  logic                 tx_valid_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 ack_s;

  nibble_sync #(
    .STAGES(SYNC_STAGES)
  ) u_ack_sync (
    .clk(clk),
    .rst(rst),
    .d  (tx_ack),
    .q  (ack_s)
  );

  // Next nibble is always the low bits of the word shifted down by one nibble.
  assign shift_next = shift_reg >> NIBBLE_W;

  // Hold off loads while the host still has ack up, so a stale ack can never
  // complete a handshake for the new word.
  assign load_ready = (state_reg == IDLE) && !ack_s && !rst;

`ifdef NIBBLE_TX_PARITY_EN
  logic tx_parity_reg;
`endif

  // Handshake FSM with registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      count_reg     <= '0;
      tx_nibble_reg <= '0;
      tx_valid_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
      tx_parity_reg <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (load_valid && load_ready) begin
            shift_reg     <= load_data;
            count_reg     <= '0;
            state_reg     <= PRESENT;
            tx_valid_reg  <= 1'b1;
            tx_nibble_reg <= load_data[NIBBLE_W-1:0];
            busy_reg      <= 1'b1;
`ifdef NIBBLE_TX_PARITY_EN
            tx_parity_reg <= nibble_parity(load_data[NIBBLE_W-1:0]);
`endif
          end
        end
        PRESENT: begin
          if (ack_s) begin
            state_reg    <= RELEASE;
            tx_valid_reg <= 1'b0;
          end
        end
        RELEASE: begin
          if (!ack_s) begin
            if (count_reg == LAST) begin
              state_reg     <= IDLE;
              done_reg      <= 1'b1;
              tx_nibble_reg <= '0;
              busy_reg      <= 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
              tx_parity_reg <= 1'b0;
`endif
            end else begin
              shift_reg     <= shift_next;
              count_reg     <= count_reg + CNT_W'(1);
              state_reg     <= PRESENT;
              tx_valid_reg  <= 1'b1;
              tx_nibble_reg <= shift_next[NIBBLE_W-1:0];
`ifdef NIBBLE_TX_PARITY_EN
              tx_parity_reg <= nibble_parity(shift_next[NIBBLE_W-1:0]);
`endif
            end
          end
        end
        default: begin
          state_reg     <= IDLE;
          tx_valid_reg  <= 1'b0;
          tx_nibble_reg <= '0;
          busy_reg      <= 1'b0;
`ifdef NIBBLE_TX_PARITY_EN
          tx_parity_reg <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign tx_nibble = tx_nibble_reg;
  assign tx_valid  = tx_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

`ifdef NIBBLE_TX_PARITY_EN
  assign tx_parity = tx_parity_reg;
`else
  assign tx_parity = 1'b0;
`endif

endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Self-checking bench for pcpi_result_nibble_tx: a word-level model (queue of
// nibbles plus a delayed view of the host ack) is compared against the DUT on
// every clock, and directed scenarios pin the model with literal sequences.
module tb_pcpi_result_nibble_tx;

  localparam int N = 8;
  localparam int S = 2;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst;
  logic         load_valid;
  logic [W-1:0] load_data;
  logic         load_ready;
  logic [3:0]   tx_nibble;
  logic         tx_valid;
  logic         tx_ack;
  logic         tx_parity;
  logic         busy;
  logic         done;

  int n_checks = 0;
  int n_errors = 0;

  // host control, written by main, read by the host process
  int host_mode = 0;   // 0: tx_ack follows man_ack, 1: automatic 4-phase host
  bit man_ack   = 1'b0;
  int host_max  = 3;

  // model state, written only by the compare process
  int       m_q[$];
  bit       m_busy;
  bit       m_valid;
  bit       m_done;
  bit [3:0] m_nib;
  bit       ack_pipe[S];
  bit       exp_ready;
  bit       prev_valid;
  int       rec_nib[$];
  int       rec_par[$];
  int       done_cnt = 0;

  pcpi_result_nibble_tx #(
    .NIBBLES(N),
    .SYNC_STAGES(S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_ready(load_ready),
    .tx_nibble (tx_nibble),
    .tx_valid  (tx_valid),
    .tx_ack    (tx_ack),
    .tx_parity (tx_parity),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Host: drives tx_ack shortly after each falling clock edge.
  initial begin : host
    int hcnt;
    tx_ack = 1'b0;
    hcnt   = 0;
    forever begin
      @(negedge clk);
      #1;
      if (host_mode == 0) begin
        tx_ack = man_ack;
      end else if (tx_valid != tx_ack) begin
        if (hcnt <= 0) begin
          tx_ack = tx_valid;
          hcnt   = $urandom_range(0, host_max);
        end else begin
          hcnt--;
        end
      end
    end
  end

  // Model step at each rising edge, then compare the DUT just after it.
  initial begin : compare
    bit ack_s_old;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        m_busy  = 1'b0;
        m_valid = 1'b0;
        m_done  = 1'b0;
        m_nib   = 4'h0;
        for (int i = 0; i < S; i++) ack_pipe[i] = 1'b0;
      end else begin
        ack_s_old = ack_pipe[S-1];
        m_done    = 1'b0;
        if (!m_busy) begin
          if (load_valid && !ack_s_old) begin
            m_q.delete();
            for (int k = 0; k < N; k++) m_q.push_back(int'(load_data[4*k +: 4]));
            m_busy  = 1'b1;
            m_valid = 1'b1;
            m_nib   = 4'(m_q[0]);
          end
        end else if (m_valid) begin
          if (ack_s_old) m_valid = 1'b0;
        end else if (!ack_s_old) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_nib  = 4'h0;
          end else begin
            m_valid = 1'b1;
            m_nib   = 4'(m_q[0]);
          end
        end
        for (int i = S - 1; i > 0; i--) ack_pipe[i] = ack_pipe[i-1];
        ack_pipe[0] = tx_ack;
      end
      exp_ready = !m_busy && !ack_pipe[S-1] && !rst;
      #1;
      chk("tx_valid", tx_valid, m_valid);
      chk("tx_nibble", tx_nibble, m_nib);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("load_ready", load_ready, exp_ready);
`ifdef NIBBLE_TX_PARITY_EN
      chk("tx_parity", tx_parity, ^m_nib);
`else
      chk("tx_parity", tx_parity, 1'b0);
`endif
      if (tx_valid && !prev_valid) begin
        rec_nib.push_back(int'(tx_nibble));
        rec_par.push_back(int'(tx_parity));
      end
      if (done) done_cnt++;
      prev_valid = tx_valid;
    end
  end

  task automatic do_load(input logic [W-1:0] data);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (load_ready) begin
        load_valid = 1'b1;
        load_data  = data;
        @(negedge clk);
        load_valid = 1'b0;
        ok = 1'b1;
      end
    end
    if (!ok) chk("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (!m_busy && !tx_valid) ok = 1'b1;
    end
    if (!ok) chk("word_timeout", 32'd0, 32'd1);
  endtask

  task automatic chk_seq(input string name, input int base, input int exp[8]);
    chk({name, "_count"}, rec_nib.size() - base, 8);
    for (int k = 0; k < 8; k++) begin
      if (base + k < rec_nib.size()) chk(name, rec_nib[base+k], exp[k]);
    end
  endtask

  initial begin : main
    int base;
    int dc;
    int lat;
    bit seen;

    rst        = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;

    // reset then idle
    repeat (2) @(negedge clk);
    chk("ready_in_reset", load_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_tx_valid", tx_valid, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_load_ready", load_ready, 1'b1);
    chk("idle_tx_nibble", tx_nibble, 4'h0);

    // full word with a cooperative host
    host_mode = 1;
    base = rec_nib.size();
    dc   = done_cnt;
    do_load(32'hDEADBEEF);
    wait_done(2000);
    chk_seq("deadbeef_nib", base, '{15, 14, 14, 11, 13, 10, 14, 13});
    chk("deadbeef_done", done_cnt - dc, 1);

    // slow host: ack held low 20 cycles after the first strobe
    host_mode = 0;
    man_ack   = 1'b0;
    base = rec_nib.size();
    do_load(32'h13579BDF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("slow_valid", tx_valid, 1'b1);
      chk("slow_nibble", tx_nibble, 4'hF);
    end
    host_mode = 1;
    wait_done(2000);
    chk_seq("slow_nib", base, '{15, 13, 11, 9, 7, 5, 3, 1});

    // ack already high at load time
    host_mode = 0;
    man_ack   = 1'b1;
    repeat (S + 3) @(negedge clk);
    base = rec_nib.size();
    load_valid = 1'b1;
    load_data  = 32'h12345678;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("ackhigh_ready", load_ready, 1'b0);
      chk("ackhigh_busy", busy, 1'b0);
    end
    man_ack = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_valid) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    load_valid = 1'b0;
    host_mode  = 1;
    chk("ackhigh_latency", lat, S + 1);
    chk("ackhigh_first", tx_nibble, 4'h8);
    wait_done(2000);
    chk_seq("ackhigh_nib", base, '{8, 7, 6, 5, 4, 3, 2, 1});

    // reset in the middle of a word
    dc = done_cnt;
    base = rec_nib.size();
    do_load(32'hCAFEF00D);
    seen = 1'b0;
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (rec_nib.size() >= base + 3) seen = 1'b1;
    end
    if (!seen) chk("midreset_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_valid", tx_valid, 1'b0);
    chk("midreset_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("midreset_no_done", done_cnt - dc, 0);
    base = rec_nib.size();
    do_load(32'h00000001);
    wait_done(2000);
    chk_seq("after_reset_nib", base, '{1, 0, 0, 0, 0, 0, 0, 0});
    chk("after_reset_done", done_cnt - dc, 1);

    // parity pattern
    base = rec_nib.size();
    do_load(32'h0000007F);
    wait_done(2000);
    for (int k = 0; k < 8; k++) begin
      if (base + k < rec_par.size()) begin
`ifdef NIBBLE_TX_PARITY_EN
        chk("parity_seq", rec_par[base+k], (k == 1) ? 1 : 0);
`else
        chk("parity_seq", rec_par[base+k], 0);
`endif
      end
    end

    // randomized traffic: load_valid mostly high, random host delays
    host_max = 4;
    dc = done_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = $urandom;
    end
    load_valid = 1'b0;
    wait_done(2000);
    chk("random_words", (done_cnt - dc) >= 5, 1'b1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
